// File: rtl/gry_ptr_fifo_pkg.sv
// Shared helpers for the Gray-pointer FIFO: pointer sizing and
// binary-to-Gray conversion.
package gry_ptr_fifo_pkg;

    function automatic int ptr_bits(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic [31:0] bin2gry(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gry_ptr_fifo_bin_gry_ctr.sv
// Binary pointer counter with a registered Gray-coded copy that always
// tracks the registered binary count.
module bin_gry_ctr
    import gry_ptr_fifo_pkg::*;
#(
    parameter int P_NUM_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [P_NUM_BITS-1:0] bin_cnt_reg,
    output logic [P_NUM_BITS-1:0] bin_cnt_comb,
    output logic [P_NUM_BITS-1:0] gry_cnt_reg
);

    assign bin_cnt_comb = bin_cnt_reg + P_NUM_BITS'(en);

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_cnt_reg <= '0;
            gry_cnt_reg <= '0;
        end else begin
            bin_cnt_reg <= bin_cnt_comb;
            gry_cnt_reg <= P_NUM_BITS'(bin2gry(32'(bin_cnt_comb)));
        end
    end

endmodule

// File: rtl/gry_ptr_fifo.sv
// Single-clock FWFT FIFO; full/empty come from Gray pointer compares,
// storage is an inferred dual-port RAM with a registered read port.
module gry_ptr_fifo
    import gry_ptr_fifo_pkg::*;
#(
    parameter int P_DEPTH = 1024,
    parameter int P_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [P_WIDTH-1:0] wr_data,
    input  logic               wr_vld,
    output logic               wr_rdy,
    output logic [P_WIDTH-1:0] rd_data,
    output logic               rd_vld,
    input  logic               rd_rdy
);

    localparam int PTR_BITS = ptr_bits(P_DEPTH);
    localparam int N = PTR_BITS + 1;
    localparam logic [N-1:0] FULL_MASK = N'(3) << (N - 2);

    logic [N-1:0] wr_bin;
    logic [N-1:0] wr_bin_next;
    logic [N-1:0] wr_gry;
    logic [N-1:0] rd_bin;
    logic [N-1:0] rd_bin_next;
    logic [N-1:0] rd_gry;
    logic         wr_en;
    logic         rd_en;
    logic         full;
    logic         empty;
    logic         unused_ptr_bits;

    logic [P_WIDTH-1:0] mem [P_DEPTH];

    assign empty  = (rd_gry == wr_gry);
    assign full   = ((wr_gry ^ FULL_MASK) == rd_gry);
    assign wr_rdy = ~full;
    assign rd_vld = ~empty;
    assign wr_en  = wr_vld & wr_rdy;
    assign rd_en  = rd_rdy & rd_vld;

    assign unused_ptr_bits = ^{wr_bin_next, rd_bin};

    bin_gry_ctr #(.P_NUM_BITS(N)) u_wr_ptr (
        .clk          (clk),
        .rst          (rst),
        .en           (wr_en),
        .bin_cnt_reg  (wr_bin),
        .bin_cnt_comb (wr_bin_next),
        .gry_cnt_reg  (wr_gry)
    );

    bin_gry_ctr #(.P_NUM_BITS(N)) u_rd_ptr (
        .clk          (clk),
        .rst          (rst),
        .en           (rd_en),
        .bin_cnt_reg  (rd_bin),
        .bin_cnt_comb (rd_bin_next),
        .gry_cnt_reg  (rd_gry)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bin[PTR_BITS-1:0]] <= wr_data;
        end
    end

    // Read at the next pointer so the new head lands with no bubble;
    // a same-address write wins over the stale RAM word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (wr_en &&
                     wr_bin[PTR_BITS-1:0] == rd_bin_next[PTR_BITS-1:0]) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_bin_next[PTR_BITS-1:0]];
        end
    end

endmodule

// File: tb/tb_gry_ptr_fifo.sv
// Scenario bench for gry_ptr_fifo at depth 4: a negedge monitor keeps
// a scoreboard of accepted words and a model of both Gray pointers.
module tb_gry_ptr_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] wr_data;
    logic             wr_vld;
    logic             wr_rdy;
    logic [WIDTH-1:0] rd_data;
    logic             rd_vld;
    logic             rd_rdy;

    int n_cmp;
    int n_bad;

    logic [WIDTH-1:0] exp_q[$];
    logic [2:0]       wr_cnt;
    logic [2:0]       rd_cnt;
    logic [2:0]       prev_wg;
    logic [2:0]       prev_rg;

    gry_ptr_fifo #(.P_DEPTH(DEPTH), .P_WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_data (wr_data),
        .wr_vld  (wr_vld),
        .wr_rdy  (wr_rdy),
        .rd_data (rd_data),
        .rd_vld  (rd_vld),
        .rd_rdy  (rd_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] gray3(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    // Inputs only change 1 time unit after posedge, so values seen at
    // negedge are exactly the ones the next posedge will act on.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            wr_cnt  = '0;
            rd_cnt  = '0;
            prev_wg = '0;
            prev_rg = '0;
        end else begin
            n_cmp++;
            if (dut.wr_gry !== gray3(wr_cnt)) begin
                n_bad++;
                $display("FAIL wr_gry: got %b want %b", dut.wr_gry, gray3(wr_cnt));
            end
            n_cmp++;
            if (dut.rd_gry !== gray3(rd_cnt)) begin
                n_bad++;
                $display("FAIL rd_gry: got %b want %b", dut.rd_gry, gray3(rd_cnt));
            end
            n_cmp++;
            if ($countones(dut.wr_gry ^ prev_wg) > 1 ||
                $countones(dut.rd_gry ^ prev_rg) > 1) begin
                n_bad++;
                $display("FAIL gray_step: wr %b->%b rd %b->%b",
                         prev_wg, dut.wr_gry, prev_rg, dut.rd_gry);
            end
            prev_wg = dut.wr_gry;
            prev_rg = dut.rd_gry;
            if (rd_vld && rd_rdy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL underflow: got %h want no word", rd_data);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        n_bad++;
                        $display("FAIL sb_data: got %h want %h", rd_data, e);
                    end
                end
                rd_cnt = rd_cnt + 3'd1;
            end
            if (wr_vld && wr_rdy) begin
                exp_q.push_back(wr_data);
                wr_cnt = wr_cnt + 3'd1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        wr_vld  = 1'b1;
        wr_data = 8'h77;
        rd_rdy  = 1'b0;
        repeat (2) step();
        n_cmp++;
        if (rd_vld !== 1'b0 || wr_rdy !== 1'b1 || rd_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_state: vld=%b rdy=%b data=%h want 0 1 00",
                     rd_vld, wr_rdy, rd_data);
        end
        rst    = 1'b0;
        wr_vld = 1'b0;
        step();
        n_cmp++;
        if (rd_vld !== 1'b0 || wr_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_nostore: vld=%b rdy=%b want 0 1", rd_vld, wr_rdy);
        end
    endtask

    task automatic test_single();
        wr_data = 8'hA5;
        wr_vld  = 1'b1;
        step();
        wr_vld = 1'b0;
        n_cmp++;
        if (rd_vld !== 1'b1 || rd_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL single_push: vld=%b data=%h want 1 a5", rd_vld, rd_data);
        end
        rd_rdy = 1'b1;
        step();
        rd_rdy = 1'b0;
        n_cmp++;
        if (rd_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL single_pop: vld=%b want 0", rd_vld);
        end
    endtask

    task automatic fill4(input logic [WIDTH-1:0] base);
        for (int i = 0; i < DEPTH; i++) begin
            wr_data = base + WIDTH'(i);
            wr_vld  = 1'b1;
            step();
        end
        wr_vld = 1'b0;
    endtask

    task automatic test_fill();
        fill4(8'h01);
        n_cmp++;
        if (wr_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_full: wr_rdy=%b want 0", wr_rdy);
        end
        wr_data = 8'h05;
        wr_vld  = 1'b1;
        step();
        wr_vld = 1'b0;
        n_cmp++;
        if (wr_rdy !== 1'b0 || rd_data !== 8'h01) begin
            n_bad++;
            $display("FAIL fill_reject: rdy=%b head=%h want 0 01", wr_rdy, rd_data);
        end
        rd_rdy = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            n_cmp++;
            if (rd_vld !== 1'b1 || rd_data !== WIDTH'(i)) begin
                n_bad++;
                $display("FAIL drain_%0d: vld=%b data=%h want 1 %h",
                         i, rd_vld, rd_data, WIDTH'(i));
            end
            step();
        end
        rd_rdy = 1'b0;
        n_cmp++;
        if (rd_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_empty: vld=%b want 0", rd_vld);
        end
    endtask

    task automatic test_back_to_back();
        int pops;
        pops   = 0;
        wr_vld = 1'b1;
        rd_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_data = 8'h10 + WIDTH'(i);
            if (i > 0) begin
                n_cmp++;
                if (rd_vld !== 1'b1 || wr_rdy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL stream_%0d: vld=%b rdy=%b want 1 1",
                             i, rd_vld, wr_rdy);
                end
            end
            if (rd_vld) pops++;
            step();
        end
        wr_vld = 1'b0;
        for (int k = 0; k < 8 && rd_vld; k++) begin
            pops++;
            step();
        end
        rd_rdy = 1'b0;
        n_cmp++;
        if (pops != 20 || rd_vld !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL stream_count: pops=%0d vld=%b left=%0d want 20 0 0",
                     pops, rd_vld, exp_q.size());
        end
    endtask

    task automatic test_full_boundary();
        int pops;
        fill4(8'h40);
        wr_data = 8'hEE;
        wr_vld  = 1'b1;
        rd_rdy  = 1'b1;
        step();
        wr_vld = 1'b0;
        rd_rdy = 1'b0;
        n_cmp++;
        if (wr_rdy !== 1'b1 || rd_vld !== 1'b1 || rd_data !== 8'h41) begin
            n_bad++;
            $display("FAIL full_pop: rdy=%b vld=%b head=%h want 1 1 41",
                     wr_rdy, rd_vld, rd_data);
        end
        pops   = 0;
        rd_rdy = 1'b1;
        for (int k = 0; k < 10 && rd_vld; k++) begin
            pops++;
            step();
        end
        rd_rdy = 1'b0;
        n_cmp++;
        if (pops != 3 || rd_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL full_occupancy: got %0d want 3", pops);
        end
    endtask

    task automatic test_mid_reset();
        wr_vld  = 1'b1;
        wr_data = 8'h11;
        step();
        wr_data = 8'h22;
        step();
        wr_vld = 1'b0;
        rst    = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (rd_vld !== 1'b0 || wr_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset: vld=%b rdy=%b want 0 1", rd_vld, wr_rdy);
        end
        wr_data = 8'h5A;
        wr_vld  = 1'b1;
        step();
        wr_vld = 1'b0;
        n_cmp++;
        if (rd_vld !== 1'b1 || rd_data !== 8'h5A) begin
            n_bad++;
            $display("FAIL post_reset: vld=%b data=%h want 1 5a", rd_vld, rd_data);
        end
        rd_rdy = 1'b1;
        step();
        rd_rdy = 1'b0;
        n_cmp++;
        if (rd_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_empty: vld=%b want 0", rd_vld);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        wr_vld  = 1'b0;
        wr_data = '0;
        rd_rdy  = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_full_boundary();
        test_mid_reset();
        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
